pow_iter: RTL and testbench



---
 rtl/pow_pkg.sv | 43 ++++
 rtl/pow_mul_trunc.sv | 20 ++
 rtl/pow_iter.sv | 187 ++++++++++++++++++
 tb/tb_pow_iter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_pkg.sv
// -----------------------------------------------------------------------------
// pow_pkg
// Shared types and helpers for the iterative power evaluator (pow_iter).
//   state_t  : controller states (IDLE, RUN, DONE)
//   class_t  : classification of an accepted request
//   is_minus1: true when a base of a given width is -1 in two's complement
// -----------------------------------------------------------------------------
package pow_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NEG_ZERO,    // 0 ** negative   -> undefined
        NEG_ONE,     // 1 ** negative   -> 1
        NEG_MINUS1,  // -1 ** negative  -> +/-1 depending on exponent parity
        NEG_OTHER,   // |base| > 1 ** negative -> 0
        ZERO_EXP,    // x ** 0          -> 1
        ITER         // non-negative, non-zero exponent: square-and-multiply
    } class_t;

    // Widest base supported by is_minus1. The caller zero-extends its base.
    localparam int MAX_WIDTH = 64;

    // The base is -1 only when it is interpreted as signed and its low
    // 'width' bits are all ones. An unsigned all-ones base is simply large.
    function automatic logic is_minus1(input logic [MAX_WIDTH-1:0] a_z,
                                       input int                   width,
                                       input logic                 a_signed);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((i < width) && !a_z[i]) begin
                all_ones = 1'b0;
            end
        end
        return a_signed & all_ones;
    endfunction

endpackage

// File: rtl/pow_mul_trunc.sv
// -----------------------------------------------------------------------------
// pow_mul_trunc
// Combinational WIDTH x WIDTH multiplier returning only the low WIDTH bits.
// The low half of a product is identical for signed and unsigned operands,
// so no signedness input is needed.
//   op_a, op_b : operands
//   prod       : (op_a * op_b) mod 2^WIDTH
// -----------------------------------------------------------------------------
module pow_mul_trunc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] prod
);

    // WIDTH-bit assignment context truncates the product to its low half.
    assign prod = op_a * op_b;

endmodule

// File: rtl/pow_iter.sv
// -----------------------------------------------------------------------------
// pow_iter
// Iterative, handshaked evaluator of the Verilog '**' operator with the result
// truncated to WIDTH bits. Base and exponent signedness are chosen per request.
// Negative exponents follow the IEEE 1364 rules; 0 ** negative is reported on
// y_undef with y = 0.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (in_ready only in IDLE)
//   a [WIDTH]           : base
//   b [EWIDTH]          : exponent
//   a_signed, b_signed  : two's-complement interpretation of a / b
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   y [WIDTH]           : result mod 2^WIDTH
//   y_undef             : result undefined (0 ** negative)
// -----------------------------------------------------------------------------
module pow_iter
    import pow_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int EWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [EWIDTH-1:0] b,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic              y_undef
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]   sq_q,      sq_d;
    logic [EWIDTH-1:0]  exp_q,     exp_d;
    logic [WIDTH-1:0]   y_q,       y_d;
    logic               y_undef_q, y_undef_d;

    logic [WIDTH-1:0]   acc_mul;
    logic [WIDTH-1:0]   sq_mul;
    logic [WIDTH-1:0]   acc_upd;
    logic [EWIDTH-1:0]  exp_shift;
    logic               neg;
    logic               a_is_minus1;
    class_t             req_class;

    // ---------------------------------------------------------------------
    // Datapath multipliers: one accumulates, one squares.
    // ---------------------------------------------------------------------
    pow_mul_trunc #(.WIDTH(WIDTH)) u_mul_acc (
        .op_a (acc_q),
        .op_b (sq_q),
        .prod (acc_mul)
    );

    pow_mul_trunc #(.WIDTH(WIDTH)) u_mul_sq (
        .op_a (sq_q),
        .op_b (sq_q),
        .prod (sq_mul)
    );

    // Multiply the accumulator in only for exponent bits that are set.
    assign acc_upd   = exp_q[0] ? acc_mul : acc_q;
    assign exp_shift = exp_q >> 1;

    // ---------------------------------------------------------------------
    // Request classification (only meaningful while in IDLE).
    // ---------------------------------------------------------------------
    assign neg         = b_signed & b[EWIDTH-1];
    assign a_is_minus1 = is_minus1(MAX_WIDTH'(a), WIDTH, a_signed);

    always_comb begin
        req_class = ITER;
        if (neg) begin
            if (a == '0) begin
                req_class = NEG_ZERO;
            end else if (a == ONE) begin
                req_class = NEG_ONE;
            end else if (a_is_minus1) begin
                req_class = NEG_MINUS1;
            end else begin
                req_class = NEG_OTHER;
            end
        end else if (b == '0) begin
            req_class = ZERO_EXP;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sq_d      = sq_q;
        exp_d     = exp_q;
        y_d       = y_q;
        y_undef_d = y_undef_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d   = DONE;
                    y_undef_d = 1'b0;
                    case (req_class)
                        NEG_ZERO: begin
                            y_d       = '0;
                            y_undef_d = 1'b1;
                        end
                        NEG_ONE:    y_d = ONE;
                        NEG_MINUS1: y_d = b[0] ? ALL_ONES : ONE;
                        NEG_OTHER:  y_d = '0;
                        ZERO_EXP:   y_d = ONE;
                        default: begin
                            // Exponent is non-negative here, so its raw bits
                            // are its unsigned magnitude.
                            state_d = RUN;
                            acc_d   = ONE;
                            sq_d    = a;
                            exp_d   = b;
                        end
                    endcase
                end
            end

            RUN: begin
                acc_d = acc_upd;
                sq_d  = sq_mul;
                exp_d = exp_shift;
                // Finish on the cycle that consumes the highest set bit.
                if (exp_shift == '0) begin
                    state_d   = DONE;
                    y_d       = acc_upd;
                    y_undef_d = 1'b0;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= ONE;
            sq_q      <= '0;
            exp_q     <= '0;
            y_q       <= '0;
            y_undef_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sq_q      <= sq_d;
            exp_q     <= exp_d;
            y_q       <= y_d;
            y_undef_q <= y_undef_d;
        end
    end

    assign y       = y_q;
    assign y_undef = y_undef_q;

endmodule

// File: tb/tb_pow_iter.sv
// -----------------------------------------------------------------------------
// tb_pow_iter
// Self-checking bench for pow_iter (WIDTH = EWIDTH = 8). Directed vectors carry
// hand-derived expectations; random requests are checked against a reference
// model that evaluates '**' by repeated multiplication.
// -----------------------------------------------------------------------------
module tb_pow_iter;

    localparam int WIDTH  = 8;
    localparam int EWIDTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [EWIDTH-1:0] b = '0;
    logic              a_signed = 1'b0;
    logic              b_signed = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  y;
    logic              y_undef;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pow_iter #(.WIDTH(WIDTH), .EWIDTH(EWIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_undef   (y_undef)
    );

    // ---------------------------------------------------------------------
    // Reference model: value semantics of '**' with 8-bit truncation, and the
    // expected accept-to-out_valid latency.
    // ---------------------------------------------------------------------
    function automatic void ref_pow(input logic [7:0] ra, input logic [7:0] rb,
                                    input logic ras, input logic rbs,
                                    output logic [7:0] ry, output logic ru,
                                    output int rlat);
        int msb;
        ru   = 1'b0;
        rlat = 1;
        if (rbs && rb[7]) begin
            if (ra == 8'd0) begin
                ry = 8'd0;
                ru = 1'b1;
            end else if (ra == 8'd1) begin
                ry = 8'd1;
            end else if (ras && ra == 8'hFF) begin
                ry = rb[0] ? 8'hFF : 8'h01;
            end else begin
                ry = 8'd0;
            end
        end else if (rb == 8'd0) begin
            ry = 8'd1;
        end else begin
            ry = 8'd1;
            for (int i = 0; i < int'(rb); i++) begin
                ry = ry * ra;
            end
            msb = 0;
            for (int i = 0; i < 8; i++) begin
                if (rb[i]) msb = i;
            end
            rlat = msb + 2;
        end
    endfunction

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    // Waits (bounded) for in_ready, presents the request for one edge.
    task automatic send_req(input logic [7:0] ta, input logic [7:0] tb_,
                            input logic tas, input logic tbs);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_req_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        a        = ta;
        b        = tb_;
        a_signed = tas;
        b_signed = tbs;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts rising edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Full transaction with out_ready held high; returns observed result.
    task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_,
                           input logic tas, input logic tbs,
                           output logic [7:0] oy, output logic ou, output int olat);
        send_req(ta, tb_, tas, tbs);
        wait_out(olat);
        oy = y;
        ou = y_undef;
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 8'h00 || y_undef !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b y=%h y_undef=%0b, required 1 0 00 0",
                     in_ready, out_valid, y, y_undef);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: in_ready=%0b out_valid=%0b y=%h", in_ready, out_valid, y);
    endtask

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vas;
        logic       vbs;
        logic [7:0] vy;
        logic       vu;
        int         vlat;
    } vec_t;

    task automatic test_directed();
        vec_t       vecs [12];
        logic [7:0] oy;
        logic       ou;
        int         olat;
        vecs[0]  = '{8'hFE, 8'h03, 1'b1, 1'b1, 8'hF8, 1'b0, 3};
        vecs[1]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1};
        vecs[2]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 9};
        vecs[3]  = '{8'hFF, 8'hFD, 1'b1, 1'b1, 8'hFF, 1'b0, 1};
        vecs[4]  = '{8'hFF, 8'hFE, 1'b1, 1'b1, 8'h01, 1'b0, 1};
        vecs[5]  = '{8'hFF, 8'hFD, 1'b0, 1'b1, 8'h00, 1'b0, 1};
        vecs[6]  = '{8'h03, 8'h02, 1'b0, 1'b0, 8'h09, 1'b0, 3};
        vecs[7]  = '{8'hFE, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 9};
        vecs[8]  = '{8'h02, 8'hFE, 1'b0, 1'b1, 8'h00, 1'b0, 1};
        vecs[9]  = '{8'h01, 8'hFD, 1'b0, 1'b1, 8'h01, 1'b0, 1};
        vecs[10] = '{8'h07, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1};
        vecs[11] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'hF3, 1'b0, 4};
        foreach (vecs[i]) begin
            run_txn(vecs[i].va, vecs[i].vb, vecs[i].vas, vecs[i].vbs, oy, ou, olat);
            checks++;
            if (oy !== vecs[i].vy || ou !== vecs[i].vu || olat != vecs[i].vlat) begin
                errors++;
                $display("FAIL directed_%0d: y=%h undef=%0b lat=%0d, required y=%h undef=%0b lat=%0d",
                         i, oy, ou, olat, vecs[i].vy, vecs[i].vu, vecs[i].vlat);
            end
            $display("directed %0d: a=%h b=%h as=%0b bs=%0b -> y=%h undef=%0b lat=%0d",
                     i, vecs[i].va, vecs[i].vb, vecs[i].vas, vecs[i].vbs, oy, ou, olat);
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, oy, ey;
        logic       ras, rbs, ou, eu;
        int         olat, elat;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: ra = 8'h00;
                1: ra = 8'h01;
                2: ra = 8'hFF;
                default: ra = 8'($urandom);
            endcase
            rb  = 8'($urandom);
            ras = 1'($urandom);
            rbs = 1'($urandom);
            ref_pow(ra, rb, ras, rbs, ey, eu, elat);
            run_txn(ra, rb, ras, rbs, oy, ou, olat);
            checks++;
            if (oy !== ey || ou !== eu || olat != elat) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h as=%0b bs=%0b y=%h undef=%0b lat=%0d, required y=%h undef=%0b lat=%0d",
                         n, ra, rb, ras, rbs, oy, ou, olat, ey, eu, elat);
            end
            $display("random %0d: a=%h b=%h as=%0b bs=%0b -> y=%h undef=%0b lat=%0d",
                     n, ra, rb, ras, rbs, oy, ou, olat);
        end
    endtask

    // Second request is presented while the first sits in DONE; it must be
    // ignored there and accepted only after the one-cycle IDLE gap.
    task automatic test_back_to_back();
        int olat;
        send_req(8'h01, 8'hFD, 1'b0, 1'b1);
        a        = 8'h02;
        b        = 8'h07;
        a_signed = 1'b0;
        b_signed = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'h01) begin
            errors++;
            $display("FAIL b2b_done: out_valid=%0b in_ready=%0b y=%h, required 1 0 01",
                     out_valid, in_ready, y);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(olat);
        checks++;
        if (y !== 8'h80 || y_undef !== 1'b0 || olat != 4) begin
            errors++;
            $display("FAIL b2b_second: y=%h undef=%0b lat=%0d, required 80 0 4", y, y_undef, olat);
        end
        $display("back_to_back: second y=%h lat=%0d", y, olat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int olat;
        out_ready = 1'b0;
        send_req(8'h05, 8'h03, 1'b0, 1'b0);
        wait_out(olat);
        checks++;
        if (out_valid !== 1'b1 || y !== 8'h7D || olat != 3) begin
            errors++;
            $display("FAIL bp_first: out_valid=%0b y=%h lat=%0d, required 1 7d 3", out_valid, y, olat);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== 8'h7D || y_undef !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%0b in_ready=%0b y=%h undef=%0b, required 1 0 7d 0",
                         k, out_valid, in_ready, y, y_undef);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h7D) begin
            errors++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b y=%h, required 0 1 7d",
                     out_valid, in_ready, y);
        end
        $display("backpressure: held y=%h for 5 cycles, released", y);
    endtask

    task automatic test_async_reset();
        logic [7:0] oy;
        logic       ou;
        int         olat;
        int         spurious;
        send_req(8'h03, 8'h80, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 8'h00 || y_undef !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%0b in_ready=%0b y=%h undef=%0b, required 0 1 00 0",
                     out_valid, in_ready, y, y_undef);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL async_reset_abort: out_valid seen %0d cycles after reset, required 0", spurious);
        end
        run_txn(8'h02, 8'h05, 1'b0, 1'b0, oy, ou, olat);
        checks++;
        if (oy !== 8'h20 || ou !== 1'b0 || olat != 4) begin
            errors++;
            $display("FAIL async_reset_next: y=%h undef=%0b lat=%0d, required 20 0 4", oy, ou, olat);
        end
        $display("async_reset: aborted run, next 2**5 -> y=%h lat=%0d", oy, olat);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
